fdiv_ctrl: RTL and testbench

FDIV_CTRL -- requirements
Module: fdiv_ctrl

---
 rtl/fdiv_ctrl_if.sv | 24 ++
 rtl/fdiv_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fdiv_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fdiv_ctrl_if.sv
// Bus bundle for fdiv_ctrl: start request, abort, operands, and registered quotient/flags.
// Handshake: En is a start request taken only while Busy is low and Kill is low; Done pulses
// one cycle when Result/NV/DZ are valid, and they hold until the next accepted request.
interface fdiv_ctrl_if;
    logic        En;
    logic        Kill;
    logic [31:0] Rs1;
    logic [31:0] Rs2;
    logic [31:0] Result;
    logic        Done;
    logic        Busy;
    logic        NV;
    logic        DZ;

    modport master (
        output En, Kill, Rs1, Rs2,
        input  Result, Done, Busy, NV, DZ
    );

    modport slave (
        input  En, Kill, Rs1, Rs2,
        output Result, Done, Busy, NV, DZ
    );
endinterface

// File: rtl/fdiv_ctrl.sv
// Multi-cycle IEEE-754 single-precision divider: restoring mantissa division, one quotient
// bit per cycle, round-to-nearest-even, flush-to-zero, with abort and registered results.
module fdiv_ctrl (
    input  logic              CLK,
    input  logic              rst_n,
    fdiv_ctrl_if.slave        bus,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [4:0]         cnt_q;
    logic [25:0]        rem_q;
    logic [25:0]        quo_q;
    logic [23:0]        div_q;
    logic signed [9:0]  exp_q;
    logic               sign_q;
    logic [31:0]        result_q;
    logic               done_q;
    logic               nv_q;
    logic               dz_q;

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    assign {sa, ea, fa} = bus.Rs1;
    assign {sb, eb, fb} = bus.Rs2;

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
    logic signed [9:0] exp_in;
    assign a_zero  = (ea == 8'd0);
    assign b_zero  = (eb == 8'd0);
    assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    assign sign_in = sa ^ sb;
    assign exp_in  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    // Special operands bypass the datapath and resolve in the accept cycle.
    logic        is_special, spec_nv, spec_dz;
    logic [31:0] spec_res;
    always_comb begin
        is_special = 1'b1;
        spec_nv    = 1'b0;
        spec_dz    = 1'b0;
        spec_res   = {sign_in, 31'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = 32'h7FC0_0000;
            spec_nv  = 1'b1;
        end else if (a_inf) begin
            spec_res = {sign_in, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_res = {sign_in, 8'hFF, 23'd0};
            spec_dz  = 1'b1;
        end else if (b_inf || a_zero) begin
            spec_res = {sign_in, 31'd0};
        end else begin
            is_special = 1'b0;
        end
    end

    logic        q_bit;
    logic [25:0] rem_sel, rem_d, quo_d;
    always_comb begin
        q_bit   = (rem_q >= {2'b00, div_q});
        rem_sel = q_bit ? (rem_q - {2'b00, div_q}) : rem_q;
        rem_d   = {rem_sel[24:0], 1'b0};
        quo_d   = {quo_q[24:0], q_bit};
    end

    // Normalise so the leading one sits in bit 25; bit 1 is guard, bit 0 folds into sticky.
    logic [25:0]       norm;
    logic signed [9:0] exp_n, exp_f;
    logic              sticky, round_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic [31:0]       round_res;
    always_comb begin
        norm      = quo_q[25] ? quo_q : {quo_q[24:0], 1'b0};
        exp_n     = quo_q[25] ? exp_q : (exp_q - 10'sd1);
        sticky    = (rem_q != 26'd0) | norm[0];
        round_up  = norm[1] & (sticky | norm[2]);
        mant_r    = {1'b0, norm[25:2]} + {24'd0, round_up};
        exp_f     = exp_n + (mant_r[24] ? 10'sd1 : 10'sd0);
        frac      = mant_r[24] ? 23'd0 : mant_r[22:0];
        if (exp_f >= 10'sd255)
            round_res = {sign_q, 8'hFF, 23'd0};
        else if (exp_f <= 10'sd0)
            round_res = {sign_q, 31'd0};
        else
            round_res = {sign_q, exp_f[7:0], frac};
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 26'd0;
            quo_q    <= 26'd0;
            div_q    <= 24'd0;
            exp_q    <= 10'sd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            nv_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.En && !bus.Kill) begin
                        cnt_q  <= 5'd0;
                        sign_q <= sign_in;
                        rem_q  <= {2'b00, 1'b1, fa};
                        div_q  <= {1'b1, fb};
                        quo_q  <= 26'd0;
                        exp_q  <= exp_in;
                        if (is_special) begin
                            result_q <= spec_res;
                            nv_q     <= spec_nv;
                            dz_q     <= spec_dz;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.Kill) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd25)
                            state_q <= ROUND;
                    end
                end
                ROUND: begin
                    if (bus.Kill) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= round_res;
                        nv_q     <= 1'b0;
                        dz_q     <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Result  = result_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = (state_q != IDLE);
    assign bus.NV      = nv_q;
    assign bus.DZ      = dz_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl: hand-computed quotients, special operands, latency,
// abort and asynchronous reset behaviour.
module tb_fdiv_ctrl;
    logic       CLK = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    fdiv_ctrl_if f ();

    fdiv_ctrl dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .bus         (f),
        .dbg_state_o (dbg_state)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] exp_q[$];
    logic [31:0] last_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one request from IDLE and check result, flags, latency, pulse width and hold.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic nv, input logic dz, input int lat);
        int          cyc;
        logic [33:0] e;
        exp_q.push_back({nv, dz, res});
        f.Rs1 = a;
        f.Rs2 = b;
        f.En  = 1'b1;
        tick();
        f.En = 1'b0;
        cyc  = 1;
        while (!f.Done && cyc < 60) begin
            tick();
            cyc++;
        end
        e = exp_q.pop_front();
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_res"}, f.Result, e[31:0]);
        check({tag, "_nv"}, {31'd0, f.NV}, {31'd0, e[33]});
        check({tag, "_dz"}, {31'd0, f.DZ}, {31'd0, e[32]});
        tick();
        check({tag, "_pulse"}, {31'd0, f.Done}, 32'd0);
        tick();
        check({tag, "_hold"}, f.Result, e[31:0]);
        last_res = e[31:0];
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (f.Done) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int cyc;
        f.En   = 1'b0;
        f.Kill = 1'b0;
        f.Rs1  = 32'd0;
        f.Rs2  = 32'd0;
        rst_n  = 1'b0;
        #7;
        check("rst_result", f.Result, 32'd0);
        check("rst_flags", {27'd0, f.Done, f.Busy, f.NV, f.DZ, 1'b0}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        #5 rst_n = 1'b1;
        tick();

        run_op("div_3_2",   32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 1'b0, 1'b0, 28);
        run_op("div_m14_m2",32'hC160_0000, 32'hC000_0000, 32'h40E0_0000, 1'b0, 1'b0, 28);
        run_op("div_1_1",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 28);
        run_op("div_m1_3",  32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 1'b0, 1'b0, 28);
        run_op("ovf",       32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 1'b0, 28);
        run_op("unf",       32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0, 28);
        run_op("dz_pos",    32'h4040_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b1, 1);
        run_op("dz_neg",    32'hC040_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b1, 1);
        run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1);
        run_op("inf_inf",   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1);
        run_op("nan_in",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1);
        run_op("inf_fin",   32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0, 1);
        run_op("fin_inf",   32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
        run_op("nzero_fin", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
        run_op("subn_fin",  32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
        run_op("div_1_3",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 28);

        // Abort at CALC cycle 10 with En also high on the same edge.
        f.Rs1 = 32'h4040_0000;
        f.Rs2 = 32'h4000_0000;
        f.En  = 1'b1;
        tick();
        f.En = 1'b0;
        cyc  = 1;
        while (cyc < 10) begin
            tick();
            cyc++;
        end
        check("kill_pre_state", {30'd0, dbg_state}, 32'd1);
        f.Kill = 1'b1;
        f.En   = 1'b1;
        tick();
        check("kill_busy", {31'd0, f.Busy}, 32'd0);
        check("kill_done", {31'd0, f.Done}, 32'd0);
        check("kill_result", f.Result, last_res);
        f.Kill = 1'b0;
        f.En   = 1'b0;
        watch_no_done("kill_no_done", 35);
        check("kill_result_after", f.Result, last_res);

        // Asynchronous reset at CALC cycle 5 after a result with NV set.
        run_op("pre_rst", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1);
        f.Rs1 = 32'h4040_0000;
        f.Rs2 = 32'h4000_0000;
        f.En  = 1'b1;
        tick();
        f.En = 1'b0;
        cyc  = 1;
        while (cyc < 5) begin
            tick();
            cyc++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_result", f.Result, 32'd0);
        check("arst_busy", {31'd0, f.Busy}, 32'd0);
        check("arst_nv", {31'd0, f.NV}, 32'd0);
        check("arst_done_dz", {30'd0, f.Done, f.DZ}, 32'd0);
        @(posedge CLK);
        #3 rst_n = 1'b1;
        watch_no_done("arst_no_done", 40);

        // En held high across DONE: the DONE cycle must not accept.
        f.Rs1 = 32'h4040_0000;
        f.Rs2 = 32'h0000_0000;
        f.En  = 1'b1;
        tick();
        check("hold_en_done1", {31'd0, f.Done}, 32'd1);
        tick();
        check("hold_en_idle", {30'd0, f.Busy, f.Done}, 32'd0);
        tick();
        check("hold_en_done2", {31'd0, f.Done}, 32'd1);
        f.En = 1'b0;
        tick();

        run_op("post_3_2", 32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 1'b0, 1'b0, 28);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
